// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IF/MEM requester and byte-wide RAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_addr, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_addr, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter sequencing 1/2/4-byte accesses onto a byte RAM; MEM_ARBITER_IO_STALL_EN adds io_full write stall
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
`ifdef MEM_ARBITER_IO_STALL_EN
  input  logic io_full,
`endif
  mem_arbiter_if.slave bus
);

  generate
    if (RD_LAT != 1) begin : g_bad_rd_lat
      $error("mem_arbiter: only RD_LAT=1 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              own_mem;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n;
  logic [2:0]        ic;
  logic [31:0]       wdata;
  logic [31:0]       res;

  logic              if_done_q;
  logic [31:0]       if_data_q;
  logic              mem_done_q;
  logic [31:0]       mem_rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;

  logic [2:0]        ic_inc;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       res_fin;
  logic [7:0]        wbyte;
  logic              io_stall;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign ic_inc    = ic + 3'd1;
  assign addr_next = base + ADDR_W'(ic_inc);

  // Byte returned this cycle belongs to the address issued one cycle earlier (ic-1).
  always_comb begin
    res_fin = res;
    case (ic)
      3'd1:    res_fin[7:0]   = bus.ram_din;
      3'd2:    res_fin[15:8]  = bus.ram_din;
      3'd3:    res_fin[23:16] = bus.ram_din;
      3'd4:    res_fin[31:24] = bus.ram_din;
      default: res_fin        = res;
    endcase
  end

  always_comb begin
    case (ic_inc)
      3'd1:    wbyte = wdata[15:8];
      3'd2:    wbyte = wdata[23:16];
      3'd3:    wbyte = wdata[31:24];
      default: wbyte = wdata[7:0];
    endcase
  end

`ifdef MEM_ARBITER_IO_STALL_EN
  assign io_stall = io_full && (ram_addr_q[17:16] == 2'b11);
`else
  assign io_stall = 1'b0;
`endif

  // Write strobe is gated live so a freeze or IO stall never emits a stray write.
  assign bus.ram_wr    = ram_wr_q & rdy & ~io_stall;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      own_mem     <= 1'b0;
      base        <= '0;
      n           <= '0;
      ic          <= '0;
      wdata       <= '0;
      res         <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          ic  <= '0;
          res <= '0;
          if (bus.mem_req) begin
            own_mem    <= 1'b1;
            base       <= bus.mem_addr;
            wdata      <= bus.mem_wdata;
            n          <= len_bytes(bus.mem_len);
            ram_addr_q <= bus.mem_addr;
            if (bus.mem_wr) begin
              state      <= WRITE;
              ram_dout_q <= bus.mem_wdata[7:0];
              ram_wr_q   <= 1'b1;
            end else begin
              state <= READ;
            end
          end else if (bus.if_req) begin
            own_mem    <= 1'b0;
            base       <= bus.if_addr;
            n          <= 3'd4;
            ram_addr_q <= bus.if_addr;
            state      <= READ;
          end
        end

        READ: begin
          if (ic == n) begin
            state <= DONE;
            if (own_mem) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= res_fin;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= res_fin;
            end
          end else begin
            res        <= res_fin;
            ic         <= ic_inc;
            ram_addr_q <= (ic_inc == n) ? '0 : addr_next;
          end
        end

        WRITE: begin
          if (!io_stall) begin
            if (ic_inc == n) begin
              state      <= DONE;
              ram_wr_q   <= 1'b0;
              ram_addr_q <= '0;
              ram_dout_q <= '0;
              if (own_mem) mem_done_q <= 1'b1;
              else         if_done_q  <= 1'b1;
            end else begin
              ic         <= ic_inc;
              ram_addr_q <= addr_next;
              ram_dout_q <= wbyte;
            end
          end
        end

        DONE: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          ic         <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
